// File: rtl/mode_pkg.sv
// Shared definitions for the mode selector: mode encoding and HEX digit patterns.
package mode_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF  = 2'd0,
        MODE_A    = 2'd1,
        MODE_B    = 2'd2,
        MODE_SCAN = 2'd3
    } mode_t;

    // Active-low seven-segment patterns, bit 7 is the decimal point (kept off).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_of(input logic [MODE_W-1:0] mode);
        logic [7:0] seg;
        case (mode)
            2'd0:    seg = SEG_0;
            2'd1:    seg = SEG_1;
            2'd2:    seg = SEG_2;
            2'd3:    seg = SEG_3;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton channel: 2-flop synchronizer, debounce counter, and a
// one-cycle pulse when the debounced level goes from released to pressed.
module key_debounce
    import mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic ADC_CLK_10,
    input  logic RESET_N,
    input  logic key_raw,
    output logic press
);

    // Guard against a zero-width counter if someone sets DEBOUNCE_CYCLES to 1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             stable;
    logic [CNT_W-1:0] count;

    // Bring the raw button into the clock domain; idle level is released (1).
    always_ff @(posedge ADC_CLK_10) begin
        if (!RESET_N) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
        end
    end

    // Accept a level change only after it has persisted; a 1->0 flip of the
    // stable level is registered as a press so the mode update sees it next cycle.
    always_ff @(posedge ADC_CLK_10) begin
        if (!RESET_N) begin
            stable <= 1'b1;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_2 == stable) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                stable <= sync_2;
                count  <= '0;
                press  <= stable;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_selector.sv
// Turns the two DE10-Lite pushbuttons and the lock switch into the 2-bit mode
// bus for the LED pattern blocks, and shows the current mode on HEX0.
module mode_selector
    import mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NUM_MODES       = 4
) (
    input  logic              ADC_CLK_10,
    input  logic              RESET_N,
    input  logic [1:0]        KEY,
    input  logic              SW_LOCK,
    output logic [MODE_W-1:0] sel,
    output logic              sel_changed,
    output logic [7:0]        HEX0
);

    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

    logic              lock_sync_1;
    logic              lock_sync_2;
    logic              press_next;
    logic              press_prev;
    logic [MODE_W-1:0] sel_next;
    logic              changed_next;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_next (
        .ADC_CLK_10(ADC_CLK_10),
        .RESET_N   (RESET_N),
        .key_raw   (KEY[0]),
        .press     (press_next)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_prev (
        .ADC_CLK_10(ADC_CLK_10),
        .RESET_N   (RESET_N),
        .key_raw   (KEY[1]),
        .press     (press_prev)
    );

    // The lock switch is only synchronized; a slide switch bounce just delays the lock slightly.
    always_ff @(posedge ADC_CLK_10) begin
        if (!RESET_N) begin
            lock_sync_1 <= 1'b0;
            lock_sync_2 <= 1'b0;
        end else begin
            lock_sync_1 <= SW_LOCK;
            lock_sync_2 <= lock_sync_1;
        end
    end

    // Step the mode with wrap-around; presses while locked are dropped, and
    // simultaneous next/prev cancel out.
    always_comb begin
        sel_next     = sel;
        changed_next = 1'b0;
        if (!lock_sync_2) begin
            if (press_next && !press_prev) begin
                sel_next     = (sel == LAST_MODE) ? '0 : sel + 1'b1;
                changed_next = 1'b1;
            end else if (press_prev && !press_next) begin
                sel_next     = (sel == '0) ? LAST_MODE : sel - 1'b1;
                changed_next = 1'b1;
            end
        end
    end

    // Mode register and its change strobe move together.
    always_ff @(posedge ADC_CLK_10) begin
        if (!RESET_N) begin
            sel         <= MODE_OFF;
            sel_changed <= 1'b0;
        end else begin
            sel         <= sel_next;
            sel_changed <= changed_next;
        end
    end

    // Display lags the mode register by one cycle.
    always_ff @(posedge ADC_CLK_10) begin
        if (!RESET_N) begin
            HEX0 <= SEG_0;
        end else begin
            HEX0 <= seg_of(sel);
        end
    end

endmodule

// File: doc/mode_selector.md
# mode_selector

Input-side front end for the LED pattern logic: it turns the DE10-Lite pushbuttons and one slide switch into the 2-bit `sel` mode bus that the pattern generators consume. Raw KEY inputs are synchronized and debounced, and each clean press steps the mode forward or backward with wrap-around. A lock switch freezes the mode. The current mode is shown on HEX0. It sits between the board pins and every `sel`-driven display block, in the same `ADC_CLK_10` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 50000, is the number of consecutive stable cycles needed to accept a level change (5 ms at 10 MHz).
- `NUM_MODES`, default 4, is the number of selectable modes, in the range 2..4.
- `ADC_CLK_10` input, 1 bit: the 10 MHz board clock and the only clock.
- `RESET_N` input, 1 bit: synchronous, active-low reset, sampled on `ADC_CLK_10` rising edge.
- `KEY` input, 2 bits: raw pushbuttons, active-low. KEY[0] = next and KEY[1] = prev.
- `SW_LOCK` input, 1 bit: raw slide switch. High means mode changes are ignored.
- `sel` output, 2 bits: current mode, 0..NUM_MODES-1.
- `sel_changed` output, 1 bit: one-cycle pulse, asserted in the same cycle `sel` takes a new value.
- `HEX0` output, 8 bits: seven-segment digit of `sel`, active-low, with bit 7 = DP (always 1, off).

## Operation
- Synchronization:
  - Each of KEY[1:0] and SW_LOCK passes through a 2-flop synchronizer.
  - Synchronizer flops reset to 1 for KEY and 0 for SW_LOCK.
- Debounce, per KEY bit:
  - Keep a stable level register (reset 1, meaning released) and a counter (reset 0).
  - If the synchronized level equals the stable level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and produces no flip.
- Press detect: a one-cycle press event fires on a stable-level 1→0 transition. Releases generate no event.
- Mode update, evaluated every cycle:
  - If SW_LOCK (synchronized) = 1, all events are discarded. They are not queued.
  - Next only: `sel` ← (`sel` = NUM_MODES-1) ? 0 : `sel`+1.
  - Prev only: `sel` ← (`sel` = 0) ? NUM_MODES-1 : `sel`-1.
  - Next and prev in the same cycle: no change and no pulse.
  - `sel_changed` = 1 exactly on cycles where `sel` is written with a new value.
- HEX0 is registered from `sel` and shows digits 0–3 in standard active-low encoding, with DP off.
- Reset values:
  - `sel` = 0, `sel_changed` = 0, HEX0 = 8'hC0 (digit 0).
  - All debounce counters = 0, stable levels = released.
- Reset mid-debounce discards the partial count. A key held through reset release produces one press event after a full debounce period.

## Timing
- Define edge N as the first clock edge at which a raw KEY level is sampled by synchronizer stage 1.
- For a clean press, the stable level flips at edge N+1+DEBOUNCE_CYCLES.
- `sel` and `sel_changed` update at edge N+2+DEBOUNCE_CYCLES.
- HEX0 updates one cycle after `sel`.
- `sel_changed` is high for exactly one cycle per accepted press.
- The maximum accepted press rate is one per 2×DEBOUNCE_CYCLES cycles per key, covering press plus release.
- SW_LOCK takes effect two cycles after its raw change. SW_LOCK is not debounced.

## Structure
- Package `mode_pkg` holds:
  - `MODE_W` = 2.
  - A mode enum: MODE_OFF=0, MODE_A=1, MODE_B=2, MODE_SCAN=3.
  - The seven-segment digit constants `SEG_0..SEG_3`.
  - The `SEG_BLANK` constant.
- Sub-module `key_debounce`, parameterized by DEBOUNCE_CYCLES, contains one synchronizer, the debounce counter, the stable level, and the press pulse output. It is instantiated twice.
- Counter width is $clog2(DEBOUNCE_CYCLES).

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and NUM_MODES = 4.
- **Reset:** hold RESET_N=0 for 3 cycles with KEY=2'b11 → `sel`=0, `sel_changed`=0, HEX0=8'hC0. Release reset → all outputs unchanged for 20 cycles.
- **Next with wrap:** four clean KEY[0] presses, each 10 cycles low and 10 high → `sel` steps 1,2,3,0. Each update coincides with a one-cycle `sel_changed` at edge N+6.
- **Prev from 0:** from `sel`=0, one clean KEY[1] press → `sel`=3, then HEX0=8'hB0 one cycle later.
- **Bounce rejection:**
  - KEY[0] toggling low 3 cycles, high 1, repeated 5 times → no `sel_changed`.
  - A following 6-cycle low → exactly one increment.
- **Simultaneous and lock:**
  - Press both keys on the same cycle → `sel` unchanged, no pulse.
  - With SW_LOCK=1, three KEY[0] presses → `sel` unchanged. Then SW_LOCK=0 and one press → exactly +1.
- **Reset mid-debounce:** KEY[0] low for 2 cycles, RESET_N=0 for 1 cycle, KEY[0] kept low → `sel`=0 after reset. `sel` becomes 1 at 6 cycles after reset release, with a single pulse.
